mem_port_responder: RTL and testbench

MEM_PORT_RESPONDER -- requirements
Module: mem_port_responder

---
 rtl/mem_port_responder.sv | 161 ++++++++++++++++
 tb/tb_mem_port_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_responder.sv
// Two-port SRAM responder: arbitrates a data port (A, read/write) and an instruction
// port (B, read-only) onto one asynchronous SRAM with a fixed strobe width per access.
module mem_port_responder #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    // data port
    input  logic        Areq,
    input  logic        Awe,
    input  logic [15:0] Aaddr,
    input  logic [15:0] Awdata,
    output logic [15:0] Ardata,
    output logic        Aack,
    // instruction port
    input  logic        Breq,
    input  logic [15:0] Baddr,
    output logic [15:0] Brdata,
    output logic        Back,
    output logic        busy,
    // external SRAM
    output logic [15:0] sram_addr,
    output logic [15:0] sram_wdata,
    output logic        sram_wdata_en,
    input  logic [15:0] sram_rdata,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {
        StIdle,
        StAccA,
        StAccB,
        StRecover
    } state_e;

    localparam logic [3:0] CntLoad = 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_b_q, last_b_d;
    logic        sel_b_q, sel_b_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] ardata_q, ardata_d;
    logic [15:0] brdata_q, brdata_d;
    logic        grant_a, grant_b;
    logic        acc_d, hold_d;

    logic        aack_q, back_q, busy_q;
    logic        ce_n_q, oe_n_q, we_n_q, wdata_en_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_b_d = last_b_q;
        sel_b_d  = sel_b_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ardata_d = ardata_q;
        brdata_d = brdata_q;
        // On a tie the port that was not served last wins.
        grant_a  = Areq && (!Breq || last_b_q);
        grant_b  = Breq && (!Areq || !last_b_q);

        unique case (state_q)
            StIdle: begin
                if (grant_a) begin
                    state_d = StAccA;
                    cnt_d   = CntLoad;
                    sel_b_d = 1'b0;
                    we_d    = Awe;
                    addr_d  = Aaddr;
                    wdata_d = Awdata;
                end else if (grant_b) begin
                    state_d = StAccB;
                    cnt_d   = CntLoad;
                    sel_b_d = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = Baddr;
                end
            end
            StAccA, StAccB: begin
                if (cnt_q == 4'd0) begin
                    state_d  = StRecover;
                    last_b_d = sel_b_q;
                    if (!we_q) begin
                        if (sel_b_q) brdata_d = sram_rdata;
                        else         ardata_d = sram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRecover: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        acc_d  = (state_d == StAccA) || (state_d == StAccB);
        // Write data stays driven through RECOVER for SRAM hold time.
        hold_d = acc_d || (state_d == StRecover);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            last_b_q   <= 1'b1;
            sel_b_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            ardata_q   <= 16'h0000;
            brdata_q   <= 16'h0000;
            aack_q     <= 1'b0;
            back_q     <= 1'b0;
            busy_q     <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            wdata_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_b_q   <= last_b_d;
            sel_b_q    <= sel_b_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ardata_q   <= ardata_d;
            brdata_q   <= brdata_d;
            aack_q     <= (state_d == StRecover) && !sel_b_d;
            back_q     <= (state_d == StRecover) && sel_b_d;
            busy_q     <= (state_d != StIdle);
            ce_n_q     <= !acc_d;
            oe_n_q     <= !(acc_d && !we_d);
            we_n_q     <= !(acc_d && we_d);
            wdata_en_q <= hold_d && we_d;
        end
    end

    assign Ardata        = ardata_q;
    assign Brdata        = brdata_q;
    assign Aack          = aack_q;
    assign Back          = back_q;
    assign busy          = busy_q;
    assign sram_addr     = addr_q;
    assign sram_wdata    = wdata_q;
    assign sram_wdata_en = wdata_en_q;
    assign sram_ce_n     = ce_n_q;
    assign sram_oe_n     = oe_n_q;
    assign sram_we_n     = we_n_q;

endmodule

// File: tb/tb_mem_port_responder.sv
// Directed bench for mem_port_responder: WAIT_CYCLES=2 main instance plus a
// WAIT_CYCLES=1 instance, both backed by a small behavioural SRAM.
module tb_mem_port_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        Areq, Awe, Breq;
    logic [15:0] Aaddr, Awdata, Baddr;
    logic [15:0] Ardata, Brdata;
    logic        Aack, Back, busy;
    logic [15:0] sram_addr, sram_wdata, sram_rdata;
    logic        sram_wdata_en, ce_n, oe_n, we_n;

    logic        Areq1, Awe1, Breq1;
    logic [15:0] Aaddr1, Awdata1, Baddr1;
    logic [15:0] Ardata1, Brdata1;
    logic        Aack1, Back1, busy1;
    logic [15:0] sram_addr1, sram_wdata1, sram_rdata1;
    logic        sram_wdata_en1, ce_n1, oe_n1, we_n1;

    logic [15:0] mem [0:255];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!ce_n && !we_n) mem[sram_addr[7:0]] <= sram_wdata;
    end
    assign sram_rdata  = mem[sram_addr[7:0]];
    assign sram_rdata1 = mem[sram_addr1[7:0]];

    mem_port_responder #(.WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst),
        .Areq(Areq), .Awe(Awe), .Aaddr(Aaddr), .Awdata(Awdata), .Ardata(Ardata), .Aack(Aack),
        .Breq(Breq), .Baddr(Baddr), .Brdata(Brdata), .Back(Back), .busy(busy),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wdata_en(sram_wdata_en),
        .sram_rdata(sram_rdata), .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n)
    );

    mem_port_responder #(.WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .Areq(Areq1), .Awe(Awe1), .Aaddr(Aaddr1), .Awdata(Awdata1), .Ardata(Ardata1),
        .Aack(Aack1),
        .Breq(Breq1), .Baddr(Baddr1), .Brdata(Brdata1), .Back(Back1), .busy(busy1),
        .sram_addr(sram_addr1), .sram_wdata(sram_wdata1), .sram_wdata_en(sram_wdata_en1),
        .sram_rdata(sram_rdata1), .sram_ce_n(ce_n1), .sram_oe_n(oe_n1), .sram_we_n(we_n1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE (called at a negedge), wait for its ack and check it.
    task automatic run_access(input string tag, input bit use_b, input bit wr,
                              input logic [15:0] addr, input logic [15:0] wd,
                              input logic [15:0] exp_rd, input logic [15:0] exp_other);
        int lo = 0;
        int cyc = 0;
        bit viol = 1'b0;
        if (use_b) begin
            Breq = 1'b1; Baddr = addr;
        end else begin
            Areq = 1'b1; Awe = wr; Aaddr = addr; Awdata = wd;
        end
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (!oe_n && !we_n) viol = 1'b1;
            if (wr && !oe_n) viol = 1'b1;
            if (Aack && Back) viol = 1'b1;
            if (wr ? !we_n : !oe_n) lo++;
            if (Aack || Back) begin
                cyc = i;
                break;
            end
        end
        Areq = 1'b0; Breq = 1'b0; Awe = 1'b0;
        chk({tag, "_latency"}, cyc, 3);
        chk({tag, "_strobe_cycles"}, lo, 2);
        chk({tag, "_strobe_rules"}, {31'd0, viol}, 0);
        chk({tag, "_ack_port"}, {30'd0, Aack, Back}, use_b ? 2'b01 : 2'b10);
        if (!wr) begin
            chk({tag, "_rdata"}, use_b ? Brdata : Ardata, exp_rd);
            chk({tag, "_other_hold"}, use_b ? Ardata : Brdata, exp_other);
        end else begin
            chk({tag, "_addr_hold"}, sram_addr, addr);
            chk({tag, "_wdata_hold"}, {sram_wdata_en, ce_n, sram_wdata}, {2'b11, wd});
        end
        @(negedge clk);
        chk({tag, "_ack_once"}, {Aack, Back, busy}, 3'b000);
    endtask

    initial begin
        int nack;
        int last_cyc;
        logic [7:0] seq;
        bit both;

        rst = 1'b0;
        Areq = 0; Awe = 0; Aaddr = 0; Awdata = 0; Breq = 0; Baddr = 0;
        Areq1 = 0; Awe1 = 0; Aaddr1 = 0; Awdata1 = 0; Breq1 = 0; Baddr1 = 0;
        #1 rst = 1'b1;
        #1;
        chk("reset_ctrl", {Aack, Back, busy, sram_wdata_en, ce_n, oe_n, we_n}, 7'b0000111);
        chk("reset_data", {sram_addr, sram_wdata, Ardata, Brdata}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Write BEEF @8001, then 1234 @0040 for the instruction-port read.
        run_access("wr_8001", 1'b0, 1'b1, 16'h8001, 16'hBEEF, 16'h0, 16'h0);
        run_access("wr_0040", 1'b0, 1'b1, 16'h0040, 16'h1234, 16'h0, 16'h0);
        run_access("b_rd_0040", 1'b1, 1'b0, 16'h0040, 16'h0, 16'h1234, 16'h0000);

        // Address change mid-access must not reach the SRAM.
        Areq = 1'b1; Awe = 1'b0; Aaddr = 16'h0040;
        @(negedge clk);
        Aaddr = 16'hFFFF;
        @(negedge clk);
        chk("addr_captured_acc", sram_addr, 16'h0040);
        @(negedge clk);
        chk("addr_captured_rec", {Aack, sram_addr}, {1'b1, 16'h0040});
        chk("addr_change_rdata", Ardata, 16'h1234);
        Areq = 1'b0;
        @(negedge clk);

        // Read after write at 0010; B data must hold.
        run_access("wr_0010", 1'b0, 1'b1, 16'h0010, 16'hA5C3, 16'h0, 16'h0);
        run_access("a_rd_0010", 1'b0, 1'b0, 16'h0010, 16'h0, 16'hA5C3, 16'h1234);

        // Reset in the second ACC_A cycle aborts the access.
        Areq = 1'b1; Awe = 1'b0; Aaddr = 16'h8001;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_acc", {busy, oe_n}, 2'b10);
        #2 rst = 1'b1;
        #1;
        chk("rst_async", {ce_n, oe_n, we_n, busy, Aack}, 5'b11100);
        @(negedge clk);
        chk("rst_no_ack", {Aack, Back, Ardata}, 18'h0);
        rst = 1'b0;
        run_access("rst_reissue", 1'b0, 1'b0, 16'h8001, 16'h0, 16'hBEEF, 16'h0000);

        // Both ports held from reset: A,B,A,B in 16 cycles.
        rst = 1'b1;
        Areq = 1'b1; Awe = 1'b0; Aaddr = 16'h8001; Breq = 1'b1; Baddr = 16'h0040;
        @(negedge clk);
        rst = 1'b0;
        nack = 0; last_cyc = 0; seq = 8'h0; both = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (Aack && Back) both = 1'b1;
            if (Aack || Back) begin
                nack++;
                last_cyc = i;
                seq = {seq[6:0], Back};
                chk("alt_rdata", Back ? Brdata : Ardata, Back ? 16'h1234 : 16'hBEEF);
            end
        end
        Areq = 1'b0; Breq = 1'b0;
        chk("alt_count", nack, 4);
        chk("alt_order", {24'd0, seq}, 32'h05);
        chk("alt_last_cycle", last_cyc, 15);
        chk("alt_no_overlap", {31'd0, both}, 0);
        @(negedge clk);
        @(negedge clk);
        chk("alt_idle", {busy, Aack, Back}, 3'b000);

        // WAIT_CYCLES=1 instance: latency 2, one strobe cycle.
        Breq1 = 1'b1; Baddr1 = 16'h0010;
        nack = 0; last_cyc = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (!oe_n1) nack++;
            if (Back1 || Aack1) begin
                last_cyc = i;
                break;
            end
        end
        Breq1 = 1'b0;
        chk("w1_latency", last_cyc, 2);
        chk("w1_strobe_cycles", nack, 1);
        chk("w1_ack_rdata", {Aack1, Back1, Brdata1}, {2'b01, 16'hA5C3});
        @(negedge clk);
        chk("w1_ack_once", {Aack1, Back1, busy1}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
